// File: rtl/rot_pkg.sv
// Shared definitions for the forward bit rotator and its inverse (bit_unrotator).
// The rotate helpers work on a wide container so any WIDTH up to ROT_MAX_W can share them.
package rot_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int ROT_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Only the low w bits of d are meaningful; the result is zero above bit w-1.
    function automatic logic [ROT_MAX_W-1:0] rot_left1(input logic [ROT_MAX_W-1:0] d,
                                                        input int w);
        logic [ROT_MAX_W-1:0] mask;
        mask = ~({ROT_MAX_W{1'b1}} << w);
        return ((d << 1) | ((d & mask) >> (w - 1))) & mask;
    endfunction

    function automatic logic [ROT_MAX_W-1:0] rot_right1(input logic [ROT_MAX_W-1:0] d,
                                                         input int w);
        logic [ROT_MAX_W-1:0] mask;
        mask = ~({ROT_MAX_W{1'b1}} << w);
        return (((d & mask) >> 1) | (d << (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/bit_unrotator.sv
// Serial inverse rotator: restores a word by applying one opposite-direction
// 1-bit rotate per clock, behind valid/ready handshakes on both sides.
module bit_unrotator
    import rot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rotate_dir,
    input  logic [AMT_W-1:0] rotate_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    state_t             state_q;
    logic [AMT_W-1:0]   cnt_q;
    logic               dir_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   step_d;

    // A left rotation is undone by right steps and vice versa.
    always_comb begin
        step_d = data_q;
        if (dir_q == DIR_LEFT)
            step_d = WIDTH'(rot_right1(ROT_MAX_W'(data_q), WIDTH));
        else
            step_d = WIDTH'(rot_left1(ROT_MAX_W'(data_q), WIDTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q  <= data_in;
                        dir_q   <= rotate_dir;
                        cnt_q   <= rotate_amt;
                        state_q <= (rotate_amt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_d;
                    cnt_q  <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1))
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) & ~reset;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT) | (state_q == ST_DONE);
    assign data_out  = data_q;

endmodule

// File: tb/tb_bit_unrotator.sv
// Directed and random checks of bit_unrotator with WIDTH=8, AMT_W=3.
module tb_bit_unrotator;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             rotate_dir;
    logic [AMT_W-1:0] rotate_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             busy;

    int tests  = 0;
    int failed = 0;

    bit_unrotator #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .rotate_dir (rotate_dir),
        .rotate_amt (rotate_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Forward rotation reference, independent of the DUT package.
    function automatic logic [7:0] fwd_rot(input logic [7:0] d, input logic dir, input int amt);
        logic [7:0] r;
        r = d;
        for (int k = 0; k < amt; k++)
            r = (dir == 1'b0) ? {r[6:0], r[7]} : {r[0], r[7:1]};
        return r;
    endfunction

    // Present one word at a negedge and let one posedge take it; returns at the next negedge.
    task automatic send(input logic [7:0] d, input logic dir, input logic [2:0] amt,
                        output bit ok);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        data_in    = d;
        rotate_dir = dir;
        rotate_amt = amt;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    // Counts negedges (from the one after accept) until out_valid; -1 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; data_in = 8'hFF; rotate_dir = 1'b0;
        rotate_amt = 3'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (data_out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_values: data_out=%h out_valid=%b busy=%b in_ready=%b, want 00 0 0 0",
                     data_out, out_valid, busy, in_ready);
        end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || data_out !== 8'h00) begin
            failed++;
            $display("FAIL reset_no_accept: busy=%b in_ready=%b data_out=%h, want 0 1 00",
                     busy, in_ready, data_out);
        end
    endtask

    task automatic test_amt1();
        bit ok; int cyc;
        send(8'hB4, 1'b0, 3'd1, ok);
        wait_valid(cyc);
        tests++;
        if (!ok || cyc !== 1) begin
            failed++;
            $display("FAIL amt1_latency: ok=%0d cycles=%0d, want 1 1", ok, cyc);
        end
        tests++;
        if (data_out !== 8'h5A) begin
            failed++;
            $display("FAIL amt1_data: data_out=%h, want 5a", data_out);
        end
        handshake();
    endtask

    task automatic test_amt3();
        bit ok; int cyc; bit rdy_seen;
        send(8'h30, 1'b1, 3'd3, ok);
        cyc = 0; rdy_seen = 1'b0;
        while (!out_valid && cyc < 50) begin
            if (in_ready || !busy) rdy_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (in_ready) rdy_seen = 1'b1;
        tests++;
        if (!ok || cyc !== 3 || !out_valid) begin
            failed++;
            $display("FAIL amt3_latency: ok=%0d cycles=%0d, want 1 3", ok, cyc);
        end
        tests++;
        if (data_out !== 8'h81) begin
            failed++;
            $display("FAIL amt3_data: data_out=%h, want 81", data_out);
        end
        tests++;
        if (rdy_seen) begin
            failed++;
            $display("FAIL amt3_in_ready_low: in_ready/busy wrong while in flight, got 1, want 0");
        end
        handshake();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h81) begin
            failed++;
            $display("FAIL amt3_after_hs: in_ready=%b out_valid=%b data_out=%h, want 1 0 81",
                     in_ready, out_valid, data_out);
        end
    endtask

    task automatic test_amt0();
        bit ok; int cyc;
        send(8'hA5, 1'b0, 3'd0, ok);
        wait_valid(cyc);
        tests++;
        if (!ok || cyc !== 0 || data_out !== 8'hA5) begin
            failed++;
            $display("FAIL amt0: ok=%0d cycles=%0d data_out=%h, want 1 0 a5", ok, cyc, data_out);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; bit bad;
        send(8'h80, 1'b0, 3'd7, ok);
        wait_valid(cyc);
        tests++;
        if (!ok || cyc !== 7 || data_out !== 8'h01) begin
            failed++;
            $display("FAIL bp_result: cycles=%0d data_out=%h, want 7 01", cyc, data_out);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2); data_in = 8'h3C; rotate_dir = 1'b1; rotate_amt = 3'd2;
            @(posedge clk);
            @(negedge clk);
            if (data_out !== 8'h01 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                bad = 1'b1;
        end
        in_valid = 1'b0;
        tests++;
        if (bad) begin
            failed++;
            $display("FAIL bp_hold: data_out=%h out_valid=%b in_ready=%b, want 01 1 0",
                     data_out, out_valid, in_ready);
        end
        handshake();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 8'h01) begin
            failed++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b data_out=%h, want 0 1 01",
                     out_valid, in_ready, data_out);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc;
        send(8'h5A, 1'b1, 3'd7, ok);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL midreset_pre: in_ready=%b busy=%b, want 0 1", in_ready, busy);
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (data_out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL midreset_clear: data_out=%h out_valid=%b busy=%b, want 00 0 0",
                     data_out, out_valid, busy);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL midreset_ready: in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        send(8'hC3, 1'b1, 3'd2, ok);
        wait_valid(cyc);
        tests++;
        if (!ok || cyc !== 2 || data_out !== 8'h0F) begin
            failed++;
            $display("FAIL midreset_fresh: cycles=%0d data_out=%h, want 2 0f", cyc, data_out);
        end
        handshake();
    endtask

    task automatic test_random();
        bit ok; int n; int nbad; logic [7:0] orig; logic dir; int amt;
        nbad = 0;
        for (int w = 0; w < 500; w++) begin
            orig = 8'($urandom);
            dir  = 1'($urandom);
            amt  = $urandom_range(0, 7);
            send(fwd_rot(orig, dir, amt), dir, 3'(amt), ok);
            n = 0;
            out_ready = 1'($urandom);
            while (!(out_valid && out_ready) && n < 100) begin
                @(negedge clk);
                out_ready = 1'($urandom);
                n++;
            end
            tests++;
            if (!ok || n >= 100 || data_out !== orig) begin
                failed++;
                nbad++;
                if (nbad < 10)
                    $display("FAIL random_word %0d: data_out=%h, want %h (dir=%0d amt=%0d)",
                             w, data_out, orig, dir, amt);
            end
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_amt1();
        test_amt3();
        test_amt0();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
